// File: rtl/mux_nch_rr.sv
// mux_nch_rr: N-channel, WIDTH-bit multiplexer with a single-entry registered
// output stage and valid/ready handshakes on every channel and on the output.
// mode=0 picks the channel from sel; mode=1 arbitrates round-robin among
// the valid channels, starting the search at the internal pointer.
module mux_nch_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_ch
);

  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic [SEL_W-1:0] out_ch_r;
  logic [SEL_W-1:0] ptr_r;

  logic             load_en_s;
  logic             fix_ok_s;
  logic             rr_found_s;
  logic [SEL_W-1:0] rr_idx_s;
  logic             grant_ok_s;
  logic [SEL_W-1:0] grant_s;
  logic [SEL_W-1:0] ptr_next_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             accept_s;

  // The output register can take a new beat when empty or being drained.
  assign load_en_s = !out_valid_r || out_ready;

  // An out-of-range select yields no grant at all.
  assign fix_ok_s = (int'(sel) < N_CH);

  // Cyclic search from ptr_r; iterating from the farthest offset down lets
  // the closest valid channel win.
  always_comb begin
    int pos;
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      pos = (int'(ptr_r) + k) % N_CH;
      if (in_valid[pos]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = SEL_W'(pos);
      end else begin
        rr_found_s = rr_found_s;
        rr_idx_s   = rr_idx_s;
      end
    end
  end

  // Mode selects which grant source drives the datapath.
  assign grant_ok_s = mode ? rr_found_s : fix_ok_s;
  assign grant_s    = mode ? rr_idx_s   : sel;

  // Pointer advances past the granted channel, wrapping N_CH-1 -> 0.
  assign ptr_next_s = (grant_s == SEL_W'(N_CH - 1)) ? '0 : grant_s + SEL_W'(1);

  // One-hot ready on the granted channel; all zero during reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = !rst && load_en_s && grant_ok_s && (grant_s == SEL_W'(i));
    end
  end

  // Data of the granted channel.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_data_s = (grant_s == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : sel_data_s;
    end
  end

  // A transfer happens only on the channel holding the single ready bit.
  assign accept_s = |(in_ready & in_valid);

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      ptr_r       <= '0;
    end else if (accept_s) begin
      out_data_r  <= sel_data_s;
      out_valid_r <= 1'b1;
      out_ch_r    <= grant_s;
      ptr_r       <= mode ? ptr_next_s : ptr_r;
    end else if (load_en_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_mux_nch_rr.sv
// tb_mux_nch_rr: scoreboard bench for mux_nch_rr; a 4-channel instance for
// most scenarios and a 3-channel instance for out-of-range select.
module tb_mux_nch_rr;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  logic        t_mode;
  logic [1:0]  t_sel;
  logic [23:0] t_in_data;
  logic [2:0]  t_in_valid;
  logic [2:0]  t_in_ready;
  logic [7:0]  t_out_data;
  logic        t_out_valid;
  logic        t_out_ready;
  logic [1:0]  t_out_ch;

  int n_checks = 0;
  int n_fail   = 0;
  beat_t sbq[$];

  mux_nch_rr #(.N_CH(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch)
  );

  mux_nch_rr #(.N_CH(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .mode(t_mode), .sel(t_sel),
    .in_data(t_in_data), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .out_data(t_out_data), .out_valid(t_out_valid), .out_ready(t_out_ready),
    .out_ch(t_out_ch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sbq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 4'hf; out_ready = 1'b1; mode = 1'b1;
    t_in_valid = 3'b111; t_out_ready = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, out_data, out_ch} !== {1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_out got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", out_valid, out_data, out_ch);
    end
    n_checks++;
    if (in_ready !== 4'b0000 || t_in_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b/%b exp 0000/000", in_ready, t_in_ready);
    end
    n_checks++;
    if ({t_out_valid, t_out_data, t_out_ch} !== {1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_out3 got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", t_out_valid, t_out_data, t_out_ch);
    end
    rst = 1'b0;
    in_valid = 4'h0; t_in_valid = 3'b000;
    tick();
  endtask

  task automatic test_fixed();
    beat_t exp_b;
    do_reset();
    mode = 1'b0; out_ready = 1'b1; in_valid = 4'hf;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      n_checks++;
      if (in_ready !== 4'(1 << s)) begin
        n_fail++;
        $display("FAIL fixed_in_ready sel=%0d got %b exp %b", s, in_ready, 4'(1 << s));
      end
      sbq.push_back('{data: 8'(8'h11 * (s + 1)), ch: 2'(s)});
      tick();
      exp_b = sbq.pop_front();
      n_checks++;
      if ({out_valid, out_data, out_ch} !== {1'b1, exp_b.data, exp_b.ch}) begin
        n_fail++;
        $display("FAIL fixed_out sel=%0d got v=%b d=%h ch=%0d exp v=1 d=%h ch=%0d",
                 s, out_valid, out_data, out_ch, exp_b.data, exp_b.ch);
      end
    end
  endtask

  task automatic test_rr_all();
    beat_t exp_b;
    int m_ptr;
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'hf;
    m_ptr = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'(1 << m_ptr)) begin
        n_fail++;
        $display("FAIL rr_all_in_ready cyc=%0d got %b exp %b", c, in_ready, 4'(1 << m_ptr));
      end
      sbq.push_back('{data: 8'(8'h11 * (m_ptr + 1)), ch: 2'(m_ptr)});
      m_ptr = (m_ptr + 1) % 4;
      tick();
      exp_b = sbq.pop_front();
      n_checks++;
      if ({out_valid, out_data, out_ch} !== {1'b1, exp_b.data, exp_b.ch}) begin
        n_fail++;
        $display("FAIL rr_all_out cyc=%0d got v=%b d=%h ch=%0d exp v=1 d=%h ch=%0d",
                 c, out_valid, out_data, out_ch, exp_b.data, exp_b.ch);
      end
    end
  endtask

  task automatic test_rr_sparse();
    beat_t exp_b;
    int exp_ch [4] = '{1, 3, 1, 3};
    do_reset();
    mode = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = (c == 0) ? 4'b0010 : 4'b1010;
      #1;
      n_checks++;
      if (in_ready !== 4'(1 << exp_ch[c])) begin
        n_fail++;
        $display("FAIL rr_sparse_in_ready cyc=%0d got %b exp %b", c, in_ready, 4'(1 << exp_ch[c]));
      end
      sbq.push_back('{data: 8'(8'h11 * (exp_ch[c] + 1)), ch: 2'(exp_ch[c])});
      tick();
      exp_b = sbq.pop_front();
      n_checks++;
      if ({out_valid, out_data, out_ch} !== {1'b1, exp_b.data, exp_b.ch}) begin
        n_fail++;
        $display("FAIL rr_sparse_out cyc=%0d got v=%b d=%h ch=%0d exp v=1 d=%h ch=%0d",
                 c, out_valid, out_data, out_ch, exp_b.data, exp_b.ch);
      end
    end
  endtask

  task automatic test_backpressure();
    beat_t exp_b;
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0010;
    sbq.push_back('{data: 8'h22, ch: 2'd1});
    tick();
    in_valid = 4'hf; out_ready = 1'b0; sel = 2'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_in_ready cyc=%0d got %b exp 0000", c, in_ready);
      end
      n_checks++;
      if ({out_valid, out_data, out_ch} !== {1'b1, sbq[0].data, sbq[0].ch}) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h ch=%0d exp v=1 d=%h ch=%0d",
                 c, out_valid, out_data, out_ch, sbq[0].data, sbq[0].ch);
      end
      tick();
    end
    void'(sbq.pop_front());
    out_ready = 1'b1;
    for (int c = 2; c < 4; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'(1 << c)) begin
        n_fail++;
        $display("FAIL bp_release_in_ready ch=%0d got %b exp %b", c, in_ready, 4'(1 << c));
      end
      sbq.push_back('{data: 8'(8'h11 * (c + 1)), ch: 2'(c)});
      tick();
      exp_b = sbq.pop_front();
      n_checks++;
      if ({out_valid, out_data, out_ch} !== {1'b1, exp_b.data, exp_b.ch}) begin
        n_fail++;
        $display("FAIL bp_release_out ch=%0d got v=%b d=%h ch=%0d exp v=1 d=%h ch=%0d",
                 c, out_valid, out_data, out_ch, exp_b.data, exp_b.ch);
      end
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    t_mode = 1'b0; t_sel = 2'd0; t_in_valid = 3'b111; t_out_ready = 1'b1;
    #1;
    n_checks++;
    if (t_in_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL oor_first_in_ready got %b exp 001", t_in_ready);
    end
    tick();
    n_checks++;
    if ({t_out_valid, t_out_data, t_out_ch} !== {1'b1, 8'h11, 2'd0}) begin
      n_fail++;
      $display("FAIL oor_first_out got v=%b d=%h ch=%0d exp v=1 d=11 ch=0", t_out_valid, t_out_data, t_out_ch);
    end
    t_sel = 2'd3; t_out_ready = 1'b0;
    #1;
    n_checks++;
    if (t_in_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL oor_hold_in_ready got %b exp 000", t_in_ready);
    end
    tick();
    n_checks++;
    if ({t_out_valid, t_out_data} !== {1'b1, 8'h11}) begin
      n_fail++;
      $display("FAIL oor_hold_out got v=%b d=%h exp v=1 d=11", t_out_valid, t_out_data);
    end
    t_out_ready = 1'b1;
    #1;
    n_checks++;
    if (t_in_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL oor_drain_in_ready got %b exp 000", t_in_ready);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (t_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL oor_drained cyc=%0d got v=%b exp v=0", c, t_out_valid);
      end
    end
    t_in_valid = 3'b000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0010;
    tick();
    n_checks++;
    if ({out_valid, out_data, out_ch} !== {1'b1, 8'h22, 2'd1}) begin
      n_fail++;
      $display("FAIL rstmid_pre got v=%b d=%h ch=%0d exp v=1 d=22 ch=1", out_valid, out_data, out_ch);
    end
    out_ready = 1'b0; rst = 1'b1; in_valid = 4'hf;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_in_ready got %b exp 0000", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_data, out_ch} !== {1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL rstmid_out got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", out_valid, out_data, out_ch);
    end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstmid_grant got %b exp 0001", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_data, out_ch} !== {1'b1, 8'h11, 2'd0}) begin
      n_fail++;
      $display("FAIL rstmid_after got v=%b d=%h ch=%0d exp v=1 d=11 ch=0", out_valid, out_data, out_ch);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'h0; out_ready = 1'b0;
    t_mode = 1'b0; t_sel = 2'd0;
    t_in_data = {8'h33, 8'h22, 8'h11};
    t_in_valid = 3'b000; t_out_ready = 1'b0;
    tick();
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_nch_rr.md
Name: mux_nch_rr

Overview:
Parametrised N-channel, WIDTH-bit multiplexer with a registered output and a valid/ready handshake on every channel and on the output. It supports two modes: fixed select, where an external sel picks the channel, and round-robin, where an internal pointer arbitrates among the valid channels. It sits wherever several producers share one consumer, and is the next generation of the 1-bit 4:1 combinational mux.

Parameters:
N_CH, 4, number of input channels (legal range 2..16).
WIDTH, 8, data width per channel in bits.
SEL_W, derived localparam = clog2(N_CH), width of sel and out_ch; not overridable.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
mode  input  1  0 = fixed select, 1 = round-robin.
sel  input  SEL_W  channel select, used only in fixed mode.
in_data  input  N_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
in_valid  input  N_CH  per-channel valid.
in_ready  output  N_CH  per-channel ready, combinational.
out_data  output  WIDTH  registered output data.
out_valid  output  1  registered output valid.
out_ready  input  1  downstream ready.
out_ch  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset: out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0. While rst=1, in_ready is all 0 and no transfers occur.
- Reset mid-operation: any beat held in the output register is discarded, and the pointer returns to 0.
- Load enable: load_en = !out_valid || out_ready, so the output register is single-entry and supports full throughput.
- Grant in fixed mode:
  - grant = sel if sel < N_CH.
  - If sel >= N_CH, there is no grant and in_ready is all 0.
- Grant in round-robin mode:
  - grant = the first i with in_valid[i]=1, searching cyclically ptr, ptr+1, ..., ptr+N_CH-1 (mod N_CH).
  - If no channel is valid, there is no grant.
- in_ready[i] = load_en && granted && (i == grant). At most one bit of in_ready is ever set.
- Accept: occurs when in_valid[grant] && in_ready[grant]. On the next edge:
  - out_data <= channel grant data, out_ch <= grant, out_valid <= 1.
  - In round-robin mode only, ptr <= (grant+1) mod N_CH, with wrap-around from N_CH-1 to 0.
- No accept while load_en=1: out_valid <= 0 on the next edge.
- Latency and throughput: latency is 1 cycle from input accept to out_valid; one beat per cycle sustained when out_ready=1.
- Backpressure: while out_valid && !out_ready:
  - out_data and out_ch are held stable.
  - in_ready is all 0 and ptr does not change.
- The pointer is unchanged in fixed mode. Switching mode preserves ptr.
- mode and sel are evaluated every cycle. A change affects only the next accept, never a beat already held.
- Simultaneous output drain and new accept in the same cycle: the register is overwritten with the new beat; there is no bubble and no loss.
- in_valid on channels without a grant is ignored; this block imposes no requirement on those producers.

Test Plan:
1. Fixed mode, N_CH=4, WIDTH=8, data ch0..3 = 0x11,0x22,0x33,0x44, all valid, out_ready=1, sel stepped 0→3 each cycle -> out_data = 0x11,0x22,0x33,0x44 with out_ch 0..3, each one cycle after its sel; in_ready is one-hot on sel.
2. Round-robin mode, all four channels valid continuously, out_ready=1 -> out_ch = 0,1,2,3,0,1 on consecutive cycles; ptr wraps from 3 to 0.
3. Round-robin mode, only ch1 and ch3 valid, ptr=2 -> ch3 is granted first, then ch1, then ch3; ch0 and ch2 never see in_ready.
4. Backpressure: beat 0x22 held with out_ready=0 for 3 cycles -> out_data=0x22 and out_valid=1 stable, in_ready=0, ptr frozen; releasing out_ready gives a back-to-back accept with no gap.
5. Fixed mode with N_CH=3 and sel=3 (out of range) -> in_ready=0 and out_valid falls to 0 after the held beat drains.
6. Assert rst while out_valid=1 and ptr=2 -> the next cycle shows out_valid=0, out_data=0, out_ch=0, and the next round-robin grant starts the search at ch0.
